// File: rtl/ctrl_decode_stage_if.sv
// rtl/ctrl_decode_stage_if.sv - handshake and control-word bundle for the decode stage
interface ctrl_decode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic        reg_write;
    logic        mem_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic        jump_src;
    logic        jalr_src;
    logic        u_src;
    logic        uj_src;
    logic        alu_src;
    logic        alu_fpu;
    logic [2:0]  branch_src;
    logic        illegal;
    logic        fpu_busy;

    modport master (
        output in_valid, instr, flush, out_ready,
        input  in_ready, out_valid, instr_out, reg_write, mem_write, mem_read,
               mem_to_reg, jump_src, jalr_src, u_src, uj_src, alu_src, alu_fpu,
               branch_src, illegal, fpu_busy
    );

    modport slave (
        input  in_valid, instr, flush, out_ready,
        output in_ready, out_valid, instr_out, reg_write, mem_write, mem_read,
               mem_to_reg, jump_src, jalr_src, u_src, uj_src, alu_src, alu_fpu,
               branch_src, illegal, fpu_busy
    );
endinterface

// File: rtl/ctrl_decode_stage.sv
// rtl/ctrl_decode_stage.sv - single-entry instruction decode stage with FPU latency hold
module ctrl_decode_stage #(
    parameter int unsigned FPU_LAT    = 3,
    parameter bit          ENABLE_FPU = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    ctrl_decode_stage_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, FULL, FPU_WAIT} state_t;

    localparam logic [3:0] LAT_M1 = 4'(FPU_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  ctrl_q, ctrl_d;
    logic [2:0]  br_q, br_d;
    logic        ill_q, ill_d;
    logic [31:0] instr_q, instr_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [9:0]  dec_ctrl;
    logic [2:0]  dec_br;
    logic        dec_ill;
    logic        accept;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];

    // ctrl bit order: reg_write,mem_write,mem_read,mem_to_reg,jump_src,jalr_src,u_src,uj_src,alu_src,alu_fpu
    always_comb begin
        dec_ctrl = 10'b0;
        dec_br   = 3'b000;
        dec_ill  = 1'b0;
        unique case (opcode)
            7'b0110011: dec_ctrl = 10'b1000000100;
            7'b0010011: dec_ctrl = 10'b1000000110;
            7'b0000011: dec_ctrl = 10'b1011000110;
            7'b1100111: dec_ctrl = 10'b1000110110;
            7'b0100011: dec_ctrl = 10'b0100000110;
            7'b0110111: dec_ctrl = 10'b1000000000;
            7'b0010111: dec_ctrl = 10'b1000001000;
            7'b1101111: dec_ctrl = 10'b1000100100;
            7'b1010011: begin
                if (ENABLE_FPU) dec_ctrl = 10'b1000000101;
                else            dec_ill  = 1'b1;
            end
            7'b1100011: begin
                unique case (funct3)
                    3'b000:  dec_br = 3'b001;
                    3'b001:  dec_br = 3'b010;
                    3'b100:  dec_br = 3'b011;
                    3'b101:  dec_br = 3'b100;
                    3'b110:  dec_br = 3'b101;
                    3'b111:  dec_br = 3'b110;
                    default: dec_ill = 1'b1;
                endcase
                if (!dec_ill) dec_ctrl = 10'b0000000100;
            end
            default: dec_ill = 1'b1;
        endcase
    end

    assign bus.in_ready = !bus.flush &&
                          (state_q == EMPTY || (state_q == FULL && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        br_d    = br_q;
        ill_d   = ill_q;
        instr_d = instr_q;
        if (bus.flush) begin
            state_d = EMPTY;
            cnt_d   = 4'd0;
            ctrl_d  = 10'b0;
            br_d    = 3'b000;
            ill_d   = 1'b0;
            instr_d = 32'b0;
        end else if (accept) begin
            ctrl_d  = dec_ctrl;
            br_d    = dec_br;
            ill_d   = dec_ill;
            instr_d = bus.instr;
            if (dec_ctrl[0] && FPU_LAT > 1) begin
                state_d = FPU_WAIT;
                cnt_d   = LAT_M1;
            end else begin
                state_d = FULL;
            end
        end else begin
            unique case (state_q)
                FPU_WAIT: begin
                    // Leave on the edge where the count lands on zero.
                    if (cnt_q <= 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = FULL;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                FULL:    if (bus.out_ready) state_d = EMPTY;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            cnt_q   <= 4'd0;
            ctrl_q  <= 10'b0;
            br_q    <= 3'b000;
            ill_q   <= 1'b0;
            instr_q <= 32'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
            br_q    <= br_d;
            ill_q   <= ill_d;
            instr_q <= instr_d;
        end
    end

    assign bus.out_valid  = (state_q == FULL);
    assign bus.fpu_busy   = (state_q == FPU_WAIT);
    assign bus.instr_out  = instr_q;
    assign bus.reg_write  = ctrl_q[9];
    assign bus.mem_write  = ctrl_q[8];
    assign bus.mem_read   = ctrl_q[7];
    assign bus.mem_to_reg = ctrl_q[6];
    assign bus.jump_src   = ctrl_q[5];
    assign bus.jalr_src   = ctrl_q[4];
    assign bus.u_src      = ctrl_q[3];
    assign bus.uj_src     = ctrl_q[2];
    assign bus.alu_src    = ctrl_q[1];
    assign bus.alu_fpu    = ctrl_q[0];
    assign bus.branch_src = br_q;
    assign bus.illegal    = ill_q;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb/tb_ctrl_decode_stage.sv - directed and random checks of ctrl_decode_stage against a transaction model
module tb_ctrl_decode_stage;
    localparam int FPU_LAT    = 3;
    localparam bit ENABLE_FPU = 1'b1;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    ctrl_decode_stage_if bus ();

    ctrl_decode_stage #(.FPU_LAT(FPU_LAT), .ENABLE_FPU(ENABLE_FPU)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: a held word, cycles left before it becomes visible, and the expected outputs.
    bit          m_have;
    int          m_left;
    logic [9:0]  m_ctrl;
    logic [2:0]  m_br;
    logic        m_ill;
    logic [31:0] m_instr;

    function automatic logic [13:0] ref_dec(input logic [31:0] i);
        logic [6:0] op;
        logic [2:0] f3;
        logic [9:0] c;
        logic [2:0] b;
        logic       il;
        op = i[6:0];
        f3 = i[14:12];
        c  = '0;
        b  = '0;
        il = 1'b0;
        if      (op == 7'b0110011) c = 10'b1000000100;
        else if (op == 7'b0010011) c = 10'b1000000110;
        else if (op == 7'b0000011) c = 10'b1011000110;
        else if (op == 7'b1100111) c = 10'b1000110110;
        else if (op == 7'b0100011) c = 10'b0100000110;
        else if (op == 7'b0110111) c = 10'b1000000000;
        else if (op == 7'b0010111) c = 10'b1000001000;
        else if (op == 7'b1101111) c = 10'b1000100100;
        else if (op == 7'b1010011 && ENABLE_FPU) c = 10'b1000000101;
        else if (op == 7'b1100011 && f3 != 3'b010 && f3 != 3'b011) begin
            c = 10'b0000000100;
            b = (f3 < 3'd2) ? f3 + 3'd1 : f3 - 3'd1;
        end else il = 1'b1;
        return {il, b, c};
    endfunction

    function automatic logic [9:0] obs_ctrl();
        return {bus.reg_write, bus.mem_write, bus.mem_read, bus.mem_to_reg, bus.jump_src,
                bus.jalr_src, bus.u_src, bus.uj_src, bus.alu_src, bus.alu_fpu};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have  = 0;
        m_left  = 0;
        m_ctrl  = '0;
        m_br    = '0;
        m_ill   = 1'b0;
        m_instr = '0;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(m_have && m_left == 0));
        chk({tag, "_fpu_busy"},  64'(bus.fpu_busy),  64'(m_have && m_left > 0));
        chk({tag, "_ctrl"},      64'(obs_ctrl()),    64'(m_ctrl));
        chk({tag, "_branch"},    64'(bus.branch_src), 64'(m_br));
        chk({tag, "_illegal"},   64'(bus.illegal),   64'(m_ill));
        chk({tag, "_instr_out"}, 64'(bus.instr_out), 64'(m_instr));
    endtask

    task automatic step(input string tag, input logic iv, input logic [31:0] ins,
                        input logic fl, input logic ordy);
        bit          exp_rdy;
        logic [13:0] d;
        bus.in_valid  = iv;
        bus.instr     = ins;
        bus.flush     = fl;
        bus.out_ready = ordy;
        #1;
        exp_rdy = !fl && (!m_have || (m_left == 0 && ordy));
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(exp_rdy));
        @(posedge clk);
        if (fl) begin
            model_reset();
        end else if (iv && exp_rdy) begin
            d       = ref_dec(ins);
            m_have  = 1;
            m_ctrl  = d[9:0];
            m_br    = d[12:10];
            m_ill   = d[13];
            m_instr = ins;
            m_left  = d[0] ? FPU_LAT - 1 : 0;
        end else if (m_have && m_left > 0) begin
            m_left--;
        end else if (m_have && ordy) begin
            m_have = 0;
        end
        #1;
        chk_outputs(tag);
    endtask

    logic [6:0] ops [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                             7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                             7'b1101111, 7'b1010011, 7'b1111111, 7'b0001111};

    initial begin
        logic [31:0] r;
        int          busy_cnt;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        rst_n = 1'b0;
        #3;
        chk_outputs("reset");
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        #9 rst_n = 1'b1;

        // add, consumed immediately
        step("add", 1'b1, 32'h002081B3, 1'b0, 1'b1);
        chk("add_ctrl_const", 64'(obs_ctrl()), 64'(10'b1000000100));
        chk("add_valid_const", 64'(bus.out_valid), 64'd1);
        step("drain0", 1'b0, 32'h0, 1'b0, 1'b1);

        // bltu stalled for three cycles
        step("bltu", 1'b1, 32'h00206463, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("bltu_hold", 1'b1, 32'h002081B3, 1'b0, 1'b0);
            chk("bltu_br_const", 64'(bus.branch_src), 64'(3'b101));
        end
        step("drain1", 1'b0, 32'h0, 1'b0, 1'b1);

        // fadd.d with FPU latency
        step("fadd", 1'b1, 32'h02208053, 1'b0, 1'b1);
        busy_cnt = 0;
        for (int i = 0; i < 8 && !bus.out_valid; i++) begin
            if (bus.fpu_busy) busy_cnt++;
            step("fadd_wait", 1'b1, 32'h002081B3, 1'b0, 1'b1);
        end
        chk("fadd_busy_cycles", 64'(busy_cnt), 64'(FPU_LAT - 1));
        chk("fadd_alu_fpu", 64'(bus.alu_fpu), 64'd1);

        // illegal encodings still flow
        step("ill_op", 1'b1, 32'h0000007F, 1'b0, 1'b1);
        chk("ill_op_flag", 64'(bus.illegal), 64'd1);
        step("ill_br", 1'b1, 32'h00002063, 1'b0, 1'b1);
        chk("ill_br_flag", 64'(bus.illegal), 64'd1);
        step("drain2", 1'b0, 32'h0, 1'b0, 1'b1);

        // flush in FULL with a competing input
        step("pre_flush", 1'b1, 32'h002081B3, 1'b0, 1'b0);
        step("flush", 1'b1, 32'h0000A083, 1'b1, 1'b1);
        chk("flush_valid", 64'(bus.out_valid), 64'd0);
        step("post_flush", 1'b0, 32'h0, 1'b0, 1'b1);

        // async reset during FPU_WAIT, then lw
        step("fadd2", 1'b1, 32'h02208053, 1'b0, 1'b1);
        chk("fadd2_busy", 64'(bus.fpu_busy), 64'd1);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_outputs("async_rst");
        #3 rst_n = 1'b1;
        step("lw", 1'b1, 32'h0000A083, 1'b0, 1'b1);
        chk("lw_ctrl_const", 64'(obs_ctrl()), 64'(10'b1011000110));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            r[6:0] = ops[$urandom_range(0, 11)];
            step("rand", 1'($urandom_range(0, 3) != 0), r,
                 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ctrl_decode_stage.md
CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 SHALL have parameter FPU_LAT, default 3, range 1..15: cycles an accepted FP-class instruction is held before its control word becomes valid.
REQ-002 SHALL have parameter ENABLE_FPU, default 1: 0 makes opcode 1010011 decode as illegal.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream instruction present.
REQ-006 SHALL have port in_ready, output, 1 bit: stage accepts an instruction this cycle.
REQ-007 SHALL have port instr, input, 32 bits: instruction; opcode is instr[6:0], funct3 is instr[14:12].
REQ-008 SHALL have port flush, input, 1 bit: synchronous pipeline kill.
REQ-009 SHALL have port out_valid, output, 1 bit: registered control word valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumes the word.
REQ-011 SHALL have port instr_out, output, 32 bits: registered copy of the accepted instruction.
REQ-012 SHALL have ports reg_write, mem_write, mem_read, mem_to_reg, jump_src, jalr_src, u_src, uj_src, alu_src, alu_fpu, each output, 1 bit, registered.
REQ-013 SHALL have port branch_src, output, 3 bits, registered: 000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu.
REQ-014 SHALL have ports illegal and fpu_busy, each output, 1 bit: registered unsupported-encoding flag, and high while in FPU_WAIT.

Function
REQ-015 SHALL decode opcode to bits {reg_write,mem_write,mem_read,mem_to_reg,jump_src,jalr_src,u_src,uj_src,alu_src,alu_fpu} as follows: 0110011 -> 1000000100, 0010011 -> 1000000110, 0000011 -> 1011000110, 1100111 -> 1000110110, 0100011 -> 0100000110.
REQ-016 SHALL also decode: 1100011 -> 0000000100, 0110111 -> 1000000000, 0010111 -> 1000001000, 1101111 -> 1000100100, 1010011 (ENABLE_FPU=1) -> 1000000101.
REQ-017 SHALL set branch_src only for opcode 1100011, mapping funct3 000/001/100/101/110/111 to 001/010/011/100/101/110; otherwise 000.
REQ-018 SHALL, for any other opcode, branch funct3 010/011, or 1010011 with ENABLE_FPU=0, register all control bits and branch_src as 0 with illegal=1; such words still flow with out_valid so a later stage can trap.
REQ-019 SHALL implement states EMPTY, FULL and FPU_WAIT.
REQ-020 SHALL drive in_ready = !flush && (state==EMPTY || (state==FULL && out_ready)); in_ready SHALL be 0 in FPU_WAIT.
REQ-021 SHALL, on accept (in_valid && in_ready), capture the decoded word and instr in the same edge; next state FPU_WAIT if alu_fpu=1 and FPU_LAT>1, else FULL.
REQ-022 SHALL, in FPU_WAIT, load a counter with FPU_LAT-1 on entry, decrement it each cycle, and go to FULL on the edge at which it reaches 0; accepted FP word therefore gets out_valid exactly FPU_LAT cycles after acceptance.
REQ-023 SHALL assert out_valid only in FULL; registered outputs SHALL hold stable while out_valid && !out_ready.
REQ-024 SHALL go FULL -> EMPTY on out_ready with no accept; on out_ready with a simultaneous accept, SHALL load the new word (back-to-back, no bubble).
REQ-025 SHALL, when flush=1, take priority over every event: next state EMPTY, counter cleared, no capture; registered control outputs SHALL clear to 0.
REQ-026 SHALL keep the counter width at 4 bits.

Reset
REQ-027 SHALL, while rst_n=0, force state EMPTY, counter 0, out_valid 0, instr_out 0, all control outputs, illegal and fpu_busy 0, independent of clk.
REQ-028 SHALL, with an asynchronous reset during FPU_WAIT, abandon the instruction; first post-reset cycle shows in_ready=1.

Verification
REQ-029 SHALL cover: add (0x002081B3) accepted, out_ready=1 -> next cycle out_valid=1, reg_write=1, uj_src=1, others 0, illegal=0.
REQ-030 SHALL cover: bltu (funct3 110) held with out_ready=0 for 3 cycles -> branch_src=101 stable, in_ready=0, out_valid=1 throughout.
REQ-031 SHALL cover: fadd.d (opcode 1010011), FPU_LAT=3 -> fpu_busy=1 for 2 cycles, in_ready=0, out_valid=1 on the 3rd cycle with alu_fpu=1.
REQ-032 SHALL cover: opcode 1111111, and opcode 1100011 funct3 010 -> out_valid=1, illegal=1, all control 0.
REQ-033 SHALL cover: flush asserted in FULL concurrent with in_valid=1 -> next cycle EMPTY, out_valid=0, input not captured.
REQ-034 SHALL cover: rst_n low mid-FPU_WAIT -> all outputs 0 immediately; after release, lw (opcode 0000011) decodes to 1011000110.
